// File: rtl/instruction_cache_sa.sv
// Set-associative fetch-stage instruction cache.
// Zero-latency hit path, single outstanding line fill, round-robin refill.
module instruction_cache_sa #(
   parameter int ADDR_WIDTH   = 32,
   parameter int LINE_WIDTH   = 128,
   parameter int NUM_SET      = 4,
   parameter int WAYS_PER_SET = 2,
   parameter int CNT_WIDTH    = 32,
   localparam int OFFSET_W    = $clog2(LINE_WIDTH / 8)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           req_valid,
   input  logic [ADDR_WIDTH-1:0]          req_addr,
   output logic                           icache_ready,
   output logic                           rsp_valid,
   output logic [LINE_WIDTH-1:0]          rsp_data,
   input  logic                           flush,
   output logic                           mem_req_valid,
   input  logic                           mem_req_ready,
   output logic [ADDR_WIDTH-OFFSET_W-1:0] mem_req_addr,
   input  logic                           mem_rsp_valid,
   input  logic [LINE_WIDTH-1:0]          mem_rsp_data,
   output logic [CNT_WIDTH-1:0]           hit_count,
   output logic [CNT_WIDTH-1:0]           miss_count
);

   localparam int SET_BITS = $clog2(NUM_SET);
   localparam int SET_W    = (SET_BITS < 1) ? 1 : SET_BITS;
   localparam int WAY_BITS = $clog2(WAYS_PER_SET);
   localparam int WAY_W    = (WAY_BITS < 1) ? 1 : WAY_BITS;
   localparam int TAG_W    = ADDR_WIDTH - OFFSET_W - SET_BITS;
   localparam int LINE_AW  = ADDR_WIDTH - OFFSET_W;

   typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT} state_t;

   state_t state_q, state_d;

   logic [TAG_W-1:0]        tag_q   [NUM_SET][WAYS_PER_SET];
   logic [LINE_WIDTH-1:0]   data_q  [NUM_SET][WAYS_PER_SET];
   logic [WAYS_PER_SET-1:0] valid_q [NUM_SET];
   logic [WAY_W-1:0]        ptr_q   [NUM_SET];

   logic [LINE_AW-1:0]    line_q;
   logic [SET_W-1:0]      set_q;
   logic [TAG_W-1:0]      mtag_q;
   logic [WAY_W-1:0]      vic_q;
   logic                  vic_ptr_q;
   logic                  flush_pend_q;
   logic [CNT_WIDTH-1:0]  hit_cnt_q;
   logic [CNT_WIDTH-1:0]  miss_cnt_q;

   logic [SET_W-1:0]      req_set;
   logic [TAG_W-1:0]      req_tag;
   logic                  hit;
   logic [LINE_WIDTH-1:0] hit_line;
   logic                  vic_inv;
   logic [WAY_W-1:0]      vic_way;
   logic                  accept;
   logic                  fill;
   logic                  flush_now;
   logic                  unused_ok;

   generate
      if (NUM_SET == 1) begin : g_one_set
         assign req_set = '0;
      end else begin : g_sets
         assign req_set = req_addr[OFFSET_W+SET_W-1:OFFSET_W];
      end
   endgenerate

   assign req_tag   = req_addr[ADDR_WIDTH-1:OFFSET_W+SET_BITS];
   assign unused_ok = ^req_addr[OFFSET_W-1:0];

   // Tag match across the ways of the addressed set, plus victim choice
   always_comb begin
      hit      = 1'b0;
      hit_line = '0;
      vic_inv  = 1'b0;
      vic_way  = ptr_q[req_set];
      for (int w = 0; w < WAYS_PER_SET; w++) begin
         if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
            hit      = 1'b1;
            hit_line = data_q[req_set][w];
         end
      end
      for (int w = WAYS_PER_SET - 1; w >= 0; w--) begin
         if (!valid_q[req_set][w]) begin
            vic_inv = 1'b1;
            vic_way = WAY_W'(w);
         end
      end
   end

   assign icache_ready  = (state_q == IDLE) && !flush && !flush_pend_q;
   assign accept        = req_valid && icache_ready;
   assign fill          = (state_q == MISS_WAIT) && mem_rsp_valid;
   assign flush_now     = (state_q == IDLE) && (flush || flush_pend_q);

   assign rsp_valid     = !reset && ((accept && hit) || fill);
   assign rsp_data      = !rsp_valid ? '0 : (fill ? mem_rsp_data : hit_line);
   assign mem_req_valid = !reset && (state_q == MISS_REQ);
   assign mem_req_addr  = mem_req_valid ? line_q : '0;
   assign hit_count     = reset ? '0 : hit_cnt_q;
   assign miss_count    = reset ? '0 : miss_cnt_q;

   // Miss FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (accept && !hit) state_d = MISS_REQ;
         MISS_REQ:  if (mem_req_ready) state_d = MISS_WAIT;
         MISS_WAIT: if (mem_rsp_valid) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Miss FSM state register
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Unreset storage: tag/data arrays and the latched miss context
   always_ff @(posedge clock) begin
      if (accept && !hit) begin
         line_q    <= req_addr[ADDR_WIDTH-1:OFFSET_W];
         set_q     <= req_set;
         mtag_q    <= req_tag;
         vic_q     <= vic_way;
         vic_ptr_q <= !vic_inv;
      end
      if (fill) begin
         tag_q[set_q][vic_q]  <= mtag_q;
         data_q[set_q][vic_q] <= mem_rsp_data;
      end
   end

   // Valid bits, replacement pointers, pending flush and counters
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < NUM_SET; s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
         flush_pend_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         if (flush_now) begin
            for (int s = 0; s < NUM_SET; s++) begin
               valid_q[s] <= '0;
               ptr_q[s]   <= '0;
            end
            flush_pend_q <= 1'b0;
         end else begin
            if (flush) flush_pend_q <= 1'b1;
            if (fill) begin
               valid_q[set_q][vic_q] <= 1'b1;
               if (vic_ptr_q) begin
                  if (int'(ptr_q[set_q]) == WAYS_PER_SET - 1)
                     ptr_q[set_q] <= '0;
                  else
                     ptr_q[set_q] <= ptr_q[set_q] + 1'b1;
               end
            end
         end
         if (accept && hit && hit_cnt_q != '1)
            hit_cnt_q <= hit_cnt_q + 1'b1;
         if (accept && !hit && miss_cnt_q != '1)
            miss_cnt_q <= miss_cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_instruction_cache_sa.sv
// Scoreboard bench for instruction_cache_sa.
// Directed misses, hits, replacement, backpressure, flush, reset, saturation.
module tb_instruction_cache_sa;

   logic         clock;
   logic         reset;
   logic         req_valid;
   logic [31:0]  req_addr;
   logic         icache_ready;
   logic         rsp_valid;
   logic [127:0] rsp_data;
   logic         flush;
   logic         mem_req_valid;
   logic         mem_req_ready;
   logic [27:0]  mem_req_addr;
   logic         mem_rsp_valid;
   logic [127:0] mem_rsp_data;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;

   logic         s_req_valid;
   logic [31:0]  s_req_addr;
   logic         s_icache_ready;
   logic         s_rsp_valid;
   logic [127:0] s_rsp_data;
   logic         s_flush;
   logic         s_mem_req_valid;
   logic         s_mem_req_ready;
   logic [27:0]  s_mem_req_addr;
   logic         s_mem_rsp_valid;
   logic [127:0] s_mem_rsp_data;
   logic [1:0]   s_hit_count;
   logic [1:0]   s_miss_count;

   int checks;
   int failures;
   logic [127:0] sb[$];

   instruction_cache_sa u_dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_addr(req_addr),
      .icache_ready(icache_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .flush(flush),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   instruction_cache_sa #(.CNT_WIDTH(2)) u_sat (
      .clock(clock), .reset(reset),
      .req_valid(s_req_valid), .req_addr(s_req_addr),
      .icache_ready(s_icache_ready),
      .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data),
      .flush(s_flush),
      .mem_req_valid(s_mem_req_valid), .mem_req_ready(s_mem_req_ready),
      .mem_req_addr(s_mem_req_addr),
      .mem_rsp_valid(s_mem_rsp_valid), .mem_rsp_data(s_mem_rsp_data),
      .hit_count(s_hit_count), .miss_count(s_miss_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic chk_cnt(input int h, input int m);
      chk("hit_count", 128'(hit_count), 128'(h));
      chk("miss_count", 128'(miss_count), 128'(m));
   endtask

   // Response monitor: every rsp_valid must match the oldest expectation
   always @(negedge clock) begin
      if (rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got rsp_data %0h required none",
                     rsp_data);
         end else begin
            chk("rsp_data", rsp_data, sb.pop_front());
         end
      end
   end

   task automatic hit_req(input logic [31:0] addr, input logic [127:0] d);
      req_valid = 1'b1;
      req_addr  = addr;
      sb.push_back(d);
      @(negedge clock);
      chk("hit_rsp_valid", 128'(rsp_valid), 128'(1));
      @(posedge clock);
      #1 req_valid = 1'b0;
   endtask

   task automatic miss_req(input logic [31:0] addr, input logic [127:0] d,
                           input int rdy_dly, input int rsp_dly,
                           input bit do_flush);
      logic [27:0] la;
      la = addr[31:4];
      req_valid = 1'b1;
      req_addr  = addr;
      @(negedge clock);
      chk("miss_ready", 128'(icache_ready), 128'(1));
      chk("miss_no_rsp", 128'(rsp_valid), 128'(0));
      @(posedge clock);
      #1 req_valid = 1'b0;
      for (int i = 0; i < rdy_dly; i++) begin
         req_valid     = 1'b1;
         req_addr      = 32'h0000_7000;
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = '1;
         @(negedge clock);
         chk("bp_req_valid", 128'(mem_req_valid), 128'(1));
         chk("bp_req_addr", 128'(mem_req_addr), 128'(la));
         chk("bp_ready", 128'(icache_ready), 128'(0));
         @(posedge clock);
         #1;
      end
      req_valid     = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clock);
      chk("mem_req_valid", 128'(mem_req_valid), 128'(1));
      chk("mem_req_addr", 128'(mem_req_addr), 128'(la));
      @(posedge clock);
      #1 mem_req_ready = 1'b0;
      for (int i = 0; i < rsp_dly; i++) begin
         flush = do_flush && (i == 0);
         @(negedge clock);
         chk("wait_req_low", 128'(mem_req_valid), 128'(0));
         @(posedge clock);
         #1 flush = 1'b0;
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = d;
      sb.push_back(d);
      @(negedge clock);
      chk("fill_rsp_valid", 128'(rsp_valid), 128'(1));
      @(posedge clock);
      #1 mem_rsp_valid = 1'b0;
   endtask

   task automatic sat_run();
      s_req_valid = 1'b1;
      s_req_addr  = 32'h0000_1000;
      @(posedge clock);
      #1 s_req_valid = 1'b0;
      s_mem_req_ready = 1'b1;
      @(posedge clock);
      #1 s_mem_req_ready = 1'b0;
      s_mem_rsp_valid = 1'b1;
      s_mem_rsp_data  = {16{8'h5A}};
      @(negedge clock);
      chk("sat_fill", 128'(s_rsp_valid), 128'(1));
      @(posedge clock);
      #1 s_mem_rsp_valid = 1'b0;
      chk("sat_miss_count", 128'(s_miss_count), 128'(1));
      for (int i = 0; i < 5; i++) begin
         s_req_valid = 1'b1;
         s_req_addr  = 32'h0000_1008;
         @(negedge clock);
         chk("sat_hit", 128'(s_rsp_valid), 128'(1));
         @(posedge clock);
         #1 s_req_valid = 1'b0;
         chk("sat_hit_count", 128'(s_hit_count),
             128'((i + 1 > 3) ? 3 : i + 1));
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      req_valid = 1'b0;
      req_addr = '0;
      flush = 1'b0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data = '0;
      s_req_valid = 1'b0;
      s_req_addr = '0;
      s_flush = 1'b0;
      s_mem_req_ready = 1'b0;
      s_mem_rsp_valid = 1'b0;
      s_mem_rsp_data = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
      chk("rst_mem_req_addr", 128'(mem_req_addr), 128'(0));
      chk("rst_rsp_data", rsp_data, 128'(0));
      chk_cnt(0, 0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("post_rst_ready", 128'(icache_ready), 128'(1));
      @(posedge clock);
      #1;

      // cold miss then hit in the same line
      miss_req(32'h0000_1000, {16{8'hA5}}, 0, 4, 1'b0);
      chk_cnt(0, 1);
      hit_req(32'h0000_1004, {16{8'hA5}});
      chk_cnt(1, 1);

      // replacement in set 0
      miss_req(32'h0000_2000, {16{8'hD2}}, 0, 1, 1'b0);
      miss_req(32'h0000_3000, {16{8'hD3}}, 0, 1, 1'b0);
      hit_req(32'h0000_2000, {16{8'hD2}});
      miss_req(32'h0000_1000, {16{8'hD1}}, 0, 2, 1'b0);
      hit_req(32'h0000_3000, {16{8'hD3}});
      hit_req(32'h0000_100C, {16{8'hD1}});
      chk_cnt(4, 4);
      miss_req(32'h0000_2000, {16{8'hD4}}, 0, 0, 1'b0);
      hit_req(32'h0000_1000, {16{8'hD1}});
      chk_cnt(5, 5);

      // backpressure on the fill request, set 1
      miss_req(32'h0000_4010, {16{8'hB1}}, 3, 2, 1'b0);
      hit_req(32'h0000_4018, {16{8'hB1}});
      chk_cnt(6, 6);

      // flush while the fill is outstanding
      miss_req(32'h0000_5000, {16{8'hC5}}, 0, 3, 1'b1);
      @(negedge clock);
      chk("pend_flush_ready", 128'(icache_ready), 128'(0));
      @(posedge clock);
      #1;
      miss_req(32'h0000_2000, {16{8'hE2}}, 0, 1, 1'b0);
      chk_cnt(6, 8);

      // flush in IDLE blocks a same-cycle request
      flush = 1'b1;
      req_valid = 1'b1;
      req_addr = 32'h0000_2000;
      @(negedge clock);
      chk("flush_ready", 128'(icache_ready), 128'(0));
      @(posedge clock);
      #1 flush = 1'b0;
      req_valid = 1'b0;
      chk_cnt(6, 8);
      miss_req(32'h0000_2000, {16{8'hE3}}, 0, 1, 1'b0);
      chk_cnt(6, 9);

      // reset during MISS_WAIT
      req_valid = 1'b1;
      req_addr = 32'h0000_6000;
      @(posedge clock);
      #1 req_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(posedge clock);
      #1 mem_req_ready = 1'b0;
      reset = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data = {16{8'h66}};
      @(negedge clock);
      chk("midrst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("midrst_rsp_data", rsp_data, 128'(0));
      chk("midrst_mem_req", 128'(mem_req_valid), 128'(0));
      chk_cnt(0, 0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("late_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("late_ready", 128'(icache_ready), 128'(1));
      chk_cnt(0, 0);
      @(posedge clock);
      #1 mem_rsp_valid = 1'b0;
      miss_req(32'h0000_1000, {16{8'hF1}}, 0, 1, 1'b0);
      chk_cnt(0, 1);

      // saturating counters on the narrow instance
      sat_run();

      repeat (2) @(posedge clock);
      #1;
      chk("sb_empty", 128'(sb.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
